// File: rtl/cla_nibble_serial_ctrl_pkg.sv
// cla_nibble_serial_ctrl_pkg: shared ALU constants (serial adder FSM states, add/sub op select)
package cla_nibble_serial_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_DONE = 2'd2
  } ctrl_state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/CLA_4bit_adder.sv
// CLA_4bit_adder: 4-bit carry-lookahead slice; in A,B,C_in; out S,C_out, group G_prime/P_prime
module CLA_4bit_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_in,
  output logic [3:0] S,
  output logic       C_out,
  output logic       G_prime,
  output logic       P_prime
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = A & B;
  assign p = A ^ B;
  assign c[0] = C_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);
  assign G_prime = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
  assign P_prime = &p;
  assign c[4] = G_prime | (P_prime & c[0]);
  assign S = p ^ c[3:0];
  assign C_out = c[4];
endmodule

// File: rtl/cla_nibble_serial_ctrl.sv
// cla_nibble_serial_ctrl: nibble-serial add/sub over one CLA slice; in clk,reset,start,sub,A,B; out ready,busy,done,result,c_out,overflow,zero
module cla_nibble_serial_ctrl
  import cla_nibble_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = $clog2(NIBBLES);
  ctrl_state_t state, state_nx;
  logic [WIDTH-1:0] opa, opb;
  logic [IW-1:0] idx;
  logic carry, last, idle_or_done, accept, co;
  logic [3:0] s;
  CLA_4bit_adder u_slice (
    .A(opa[{idx, 2'b00} +: 4]),
    .B(opb[{idx, 2'b00} +: 4]),
    .C_in(carry),
    .S(s),
    .C_out(co),
    .G_prime(),
    .P_prime()
  );
  assign idle_or_done = state == CTRL_IDLE || state == CTRL_DONE;
  assign accept = idle_or_done && start;
  assign last = idx == IW'(NIBBLES - 1);
  assign busy = state == CTRL_RUN;
  assign ready = ~busy;
  assign done = state == CTRL_DONE;
  always_comb begin
    state_nx = accept ? CTRL_RUN : busy ? (last ? CTRL_DONE : CTRL_RUN) : CTRL_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= CTRL_IDLE;
    else state <= state_nx;
  end
  // the unused fourth encoding is cleared exactly like reset
  always_ff @(posedge clk) begin
    if (reset || !(idle_or_done || busy)) begin
      opa <= '0;
      opb <= '0;
      carry <= 1'b0;
      idx <= '0;
      result <= '0;
      c_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      opa <= A;
      opb <= (sub == OP_SUB) ? ~B : B;
      carry <= sub;
      idx <= '0;
      result <= '0;
      c_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (busy) begin
      result[{idx, 2'b00} +: 4] <= s;
      carry <= co;
      idx <= idx + 1'b1;
      if (last) begin
        c_out <= co;
        // carry into the sign bit recovered from the top nibble's sum bit
        overflow <= opa[WIDTH-1] ^ opb[WIDTH-1] ^ s[3] ^ co;
        zero <= ~|result[WIDTH-5:0] && ~|s;
      end
    end
  end
endmodule

// File: tb/tb_cla_nibble_serial_ctrl.sv
// tb_cla_nibble_serial_ctrl: table-driven scoreboard bench for the nibble-serial adder controller
module tb_cla_nibble_serial_ctrl;
  typedef struct {
    logic [31:0] r;
    logic c, v, z;
    int t;
  } exp_t;
  typedef struct {
    logic [31:0] a, b;
    logic s;
    logic [31:0] r;
    logic c, v, z;
  } vec_t;
  logic clk = 1'b0;
  logic reset, start, sub;
  logic [31:0] A, B, result;
  logic ready, busy, done, c_out, overflow, zero;
  int tests = 0, fails = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;
  exp_t q[$];
  vec_t vt[8];
  cla_nibble_serial_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .c_out(c_out), .overflow(overflow), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic [31:0] bb;
    logic [32:0] sum;
    bb = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + 33'(s);
    e.r = sum[31:0];
    e.c = sum[32];
    e.v = (a[31] == bb[31]) && (e.r[31] != a[31]);
    e.z = e.r == 0;
    e.t = 0;
    return e;
  endfunction
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e, input bit push);
    exp_t x;
    x = e;
    x.t = cyc;
    A = a; B = b; sub = s; start = 1'b1;
    busy_cnt = 0;
    if (push) q.push_back(x);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; sub = 1'($urandom);
  endtask
  task automatic wait_done(input string n);
    int k;
    exp_t e;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({n, "_done_seen"}, done, 1);
    chk({n, "_sb_depth"}, q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({n, "_result"}, result, e.r);
      chk({n, "_c_out"}, c_out, e.c);
      chk({n, "_overflow"}, overflow, e.v);
      chk({n, "_zero"}, zero, e.z);
      chk({n, "_latency"}, cyc - e.t, 9);
      chk({n, "_busy_cycles"}, busy_cnt, 8);
      chk({n, "_ready"}, ready, 1);
    end
  endtask
  initial begin
    vt[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vt[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[5] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_flags", {c_out, overflow, zero, done, busy}, 0);
    chk("rst_ready", ready, 1);
    reset = 1'b0;
    @(negedge clk);
    foreach (vt[i]) begin
      exp_t e;
      e.r = vt[i].r; e.c = vt[i].c; e.v = vt[i].v; e.z = vt[i].z; e.t = 0;
      issue(vt[i].a, vt[i].b, vt[i].s, e, 1'b1);
      wait_done($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'($urandom);
      issue(a, b, s, model(a, b, s), 1'b1);
      wait_done($sformatf("rnd%0d", i));
      @(negedge clk);
    end
    issue(32'h5, 32'h3, 1'b0, model(32'h5, 32'h3, 1'b0), 1'b1);
    repeat (2) @(negedge clk);
    A = 32'h100; B = 32'h100; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done("ignored_start");
    issue(32'h10, 32'h20, 1'b0, model(32'h10, 32'h20, 1'b0), 1'b1);
    wait_done("back_to_back");
    chk("b2b_result_const", result, 32'h30);
    @(negedge clk);
    issue(32'h12345678, 32'h11111111, 1'b0, model(32'h0, 32'h0, 1'b0), 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    done_cnt = 0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    issue(32'h12345678, 32'h11111111, 1'b0, model(32'h12345678, 32'h11111111, 1'b0), 1'b1);
    wait_done("after_reset");
    chk("after_reset_const", result, 32'h23456789);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
